// File: rtl/rv_pkg.sv
// Shared types and SoC address-map constants for the data-side interconnect.
// Slave defaults describe the FPGA SoC map: SRAM low, memory-mapped peripherals above.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] SRAM_BASE = 32'h0000_0000;
  localparam logic [XLEN-1:0] SRAM_MASK = 32'hF000_0000;
  localparam logic [XLEN-1:0] HEX_BASE  = 32'h1000_0000;
  localparam logic [XLEN-1:0] HEX_MASK  = 32'hFFFF_FF00;
  localparam logic [XLEN-1:0] KEY_BASE  = 32'h1000_0100;
  localparam logic [XLEN-1:0] KEY_MASK  = 32'hFFFF_FF00;
  localparam logic [XLEN-1:0] SPI_BASE  = 32'h1000_0200;
  localparam logic [XLEN-1:0] SPI_MASK  = 32'hFFFF_FF00;

  localparam int DEF_SLAVES = 4;
  localparam logic [DEF_SLAVES-1:0][XLEN-1:0] DEF_BASE =
    {SPI_BASE, KEY_BASE, HEX_BASE, SRAM_BASE};
  localparam logic [DEF_SLAVES-1:0][XLEN-1:0] DEF_MASK =
    {SPI_MASK, KEY_MASK, HEX_MASK, SRAM_MASK};

  localparam logic [XLEN-1:0] XBAR_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_UNMAPPED = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_PROTOCOL = 2'b11
  } xbar_err_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR
  } xbar_state_e;

  // A single-slave build still needs a one-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rv_xbar_decoder.sv
// Combinational address decoder: base/mask match per slave, lowest index wins.
// Shared by the data-side and the future instruction-side crossbar.
module rv_xbar_decoder
  import rv_pkg::*;
#(
  parameter int                                NUM_SLAVES = DEF_SLAVES,
  parameter logic [NUM_SLAVES-1:0][XLEN-1:0]   SLAVE_BASE = DEF_BASE,
  parameter logic [NUM_SLAVES-1:0][XLEN-1:0]   SLAVE_MASK = DEF_MASK,
  localparam int                               IDX_W      = idx_width(NUM_SLAVES)
) (
  input  logic [XLEN-1:0]       addr,
  output logic [NUM_SLAVES-1:0] onehot,
  output logic [IDX_W-1:0]      idx,
  output logic                  hit
);

  // NOTE: every output gets a default before the loop, otherwise a miss would
  // leave it unassigned and infer a latch.
  always_comb begin
    idx = '0;
    hit = 1'b0;
    // Scanning downwards lets the lowest matching slave be the last writer.
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & SLAVE_MASK[i]) == SLAVE_BASE[i]) begin
        idx = IDX_W'(i);
        hit = 1'b1;
      end
    end
    onehot = hit ? (NUM_SLAVES'(1) << idx) : '0;
  end

endmodule

// File: rtl/rv_data_xbar.sv
// Data-side crossbar: one core data port fanned out to address-decoded slaves,
// single outstanding transaction, error responses for miss, timeout and misuse.
module rv_data_xbar
  import rv_pkg::*;
#(
  parameter int                              NUM_SLAVES = DEF_SLAVES,
  parameter logic [NUM_SLAVES-1:0][XLEN-1:0] SLAVE_BASE = DEF_BASE,
  parameter logic [NUM_SLAVES-1:0][XLEN-1:0] SLAVE_MASK = DEF_MASK,
  parameter int                              TIMEOUT    = 255,
  parameter logic [XLEN-1:0]                 ERR_DATA   = XBAR_ERR_DATA
) (
  input  logic                             clk_i,
  input  logic                             arstn_i,
  input  logic                             data_req_i,
  input  logic                             data_we_i,
  input  logic [XLEN/8-1:0]                data_be_i,
  input  logic [XLEN-1:0]                  data_addr_i,
  input  logic [XLEN-1:0]                  data_wdata_i,
  output logic                             data_rvalid_o,
  output logic [XLEN-1:0]                  data_rdata_o,
  output logic [NUM_SLAVES-1:0]            slv_req_o,
  output logic                             slv_we_o,
  output logic [XLEN/8-1:0]                slv_be_o,
  output logic [XLEN-1:0]                  slv_wdata_o,
  output logic [XLEN-1:0]                  slv_addr_o,
  input  logic [NUM_SLAVES-1:0]            slv_rvalid_i,
  input  logic [NUM_SLAVES-1:0][XLEN-1:0]  slv_rdata_i,
  output logic                             err_o,
  output logic [1:0]                       err_code_o,
  output logic [XLEN-1:0]                  err_addr_o
);

  localparam int                IDX_W    = idx_width(NUM_SLAVES);
  localparam int                TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);

  xbar_state_e       state;
  logic [IDX_W-1:0]  sel;
  logic [XLEN-1:0]   addr_q;
  logic [TMR_W-1:0]  timer;
  xbar_err_e         code_q;
  logic [XLEN-1:0]   err_addr_q;

  logic [NUM_SLAVES-1:0] dec_onehot;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_hit;

  logic       new_req;
  logic       sel_rvalid;
  logic       timeout_hit;
  logic       tx_err;
  logic       proto_err;
  xbar_err_e  cur_code;
  logic [XLEN-1:0] cur_addr;

  rv_xbar_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decoder (
    .addr   (data_addr_i),
    .onehot (dec_onehot),
    .idx    (dec_idx),
    .hit    (dec_hit)
  );

  assign slv_we_o    = data_we_i;
  assign slv_be_o    = data_be_i;
  assign slv_wdata_o = data_wdata_i;
  assign slv_addr_o  = data_addr_i & ~SLAVE_MASK[dec_idx];

  // Both request and response paths are combinational so the xbar adds no latency;
  // everything is gated by reset so a held reset presents a quiet bus.
  always_comb begin
    new_req     = arstn_i & data_req_i;
    sel_rvalid  = slv_rvalid_i[sel];
    timeout_hit = arstn_i && (state == ST_WAIT) && !sel_rvalid && (timer == TMR_LAST);
    tx_err      = arstn_i && ((state == ST_ERR) || timeout_hit);
    proto_err   = new_req && (state != ST_IDLE);
    err_o       = tx_err | proto_err;
    slv_req_o   = (new_req && (state == ST_IDLE) && dec_hit) ? dec_onehot : '0;

    data_rvalid_o = 1'b0;
    data_rdata_o  = '0;
    if (arstn_i) begin
      unique case (state)
        ST_WAIT: begin
          data_rvalid_o = sel_rvalid | timeout_hit;
          data_rdata_o  = timeout_hit ? ERR_DATA : slv_rdata_i[sel];
        end
        ST_ERR: begin
          data_rvalid_o = 1'b1;
          data_rdata_o  = ERR_DATA;
        end
        default: ;
      endcase
    end

    // The outstanding transaction's own error outranks a same-cycle protocol error.
    if (state == ST_ERR)  cur_code = ERR_UNMAPPED;
    else if (timeout_hit) cur_code = ERR_TIMEOUT;
    else                  cur_code = ERR_PROTOCOL;
    cur_addr   = tx_err ? addr_q : data_addr_i;
    err_code_o = err_o ? cur_code : code_q;
    err_addr_o = err_o ? cur_addr : err_addr_q;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples the pre-edge values of its peers.
  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state      <= ST_IDLE;
      sel        <= '0;
      addr_q     <= '0;
      timer      <= '0;
      code_q     <= ERR_NONE;
      err_addr_q <= '0;
    end else begin
      if (err_o) begin
        code_q     <= cur_code;
        err_addr_q <= cur_addr;
      end
      unique case (state)
        ST_IDLE: begin
          if (new_req) begin
            addr_q <= data_addr_i;
            timer  <= '0;
            if (dec_hit) begin
              sel   <= dec_idx;
              state <= ST_WAIT;
            end else begin
              state <= ST_ERR;
            end
          end
        end
        ST_WAIT: begin
          if (sel_rvalid || timeout_hit) state <= ST_IDLE;
          else if (timer != '1)          timer <= timer + 1'b1;
        end
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_data_xbar.sv
// Randomised scoreboard bench for rv_data_xbar: the driver predicts each response
// from the address map and slave latency, a negedge monitor checks what appears.
module tb_rv_data_xbar;

  localparam int NS  = 4;
  localparam int TMO = 8;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  // Map under test: slave 2 overlaps slave 0 on the low page.
  localparam logic [NS-1:0][31:0] TB_BASE =
    {32'h2000_0000, 32'h0000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [NS-1:0][31:0] TB_MASK =
    {32'hF000_0000, 32'hFFFF_FF00, 32'hF000_0000, 32'hF000_0000};

  // Reference map as plain lists.
  logic [31:0] m_base [NS] = '{32'h0000_0000, 32'h1000_0000, 32'h0000_0000, 32'h2000_0000};
  logic [31:0] m_mask [NS] = '{32'hF000_0000, 32'hF000_0000, 32'hFFFF_FF00, 32'hF000_0000};

  logic                 clk = 1'b0;
  logic                 arstn = 1'b0;
  logic                 data_req = 1'b0;
  logic                 data_we = 1'b0;
  logic [3:0]           data_be = '0;
  logic [31:0]          data_addr = '0;
  logic [31:0]          data_wdata = '0;
  logic                 data_rvalid;
  logic [31:0]          data_rdata;
  logic [NS-1:0]        slv_req;
  logic                 slv_we;
  logic [3:0]           slv_be;
  logic [31:0]          slv_wdata;
  logic [31:0]          slv_addr;
  logic [NS-1:0]        slv_rvalid = '0;
  logic [NS-1:0][31:0]  slv_rdata = '0;
  logic                 err;
  logic [1:0]           err_code;
  logic [31:0]          err_addr;

  rv_data_xbar #(
    .NUM_SLAVES (NS),
    .SLAVE_BASE (TB_BASE),
    .SLAVE_MASK (TB_MASK),
    .TIMEOUT    (TMO),
    .ERR_DATA   (ERRD)
  ) dut (
    .clk_i         (clk),
    .arstn_i       (arstn),
    .data_req_i    (data_req),
    .data_we_i     (data_we),
    .data_be_i     (data_be),
    .data_addr_i   (data_addr),
    .data_wdata_i  (data_wdata),
    .data_rvalid_o (data_rvalid),
    .data_rdata_o  (data_rdata),
    .slv_req_o     (slv_req),
    .slv_we_o      (slv_we),
    .slv_be_o      (slv_be),
    .slv_wdata_o   (slv_wdata),
    .slv_addr_o    (slv_addr),
    .slv_rvalid_i  (slv_rvalid),
    .slv_rdata_i   (slv_rdata),
    .err_o         (err),
    .err_code_o    (err_code),
    .err_addr_o    (err_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] rdata;
    bit          is_err;
    logic [1:0]  code;
    logic [31:0] addr;
    int          at;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  bit          started = 1'b0;
  bit          exp_proto = 1'b0;
  logic [1:0]  last_code = 2'b00;
  logic [31:0] last_addr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // First slave (lowest index) whose masked address equals its base.
  task automatic model_decode(input logic [31:0] a, output bit hit, output int sel);
    hit = 1'b0;
    sel = 0;
    for (int i = 0; i < NS; i++) begin
      if (!hit && ((a & m_mask[i]) == m_base[i])) begin
        hit = 1'b1;
        sel = i;
      end
    end
  endtask

  // Monitor: every response is matched against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (started && arstn) begin
      if (data_rvalid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rvalid", {63'd0, data_rvalid}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("resp_cycle", 64'(cyc), 64'(e.at));
          check("resp_rdata", {32'd0, data_rdata}, {32'd0, e.rdata});
          check("resp_err_o", {63'd0, err}, {63'd0, e.is_err});
          if (e.is_err) begin
            last_code = e.code;
            last_addr = e.addr;
          end
        end
      end else begin
        check("err_o_no_resp", {63'd0, err}, {63'd0, exp_proto});
      end
      check("err_code_o", {62'd0, err_code}, {62'd0, last_code});
      check("err_addr_o", {32'd0, err_addr}, {32'd0, last_addr});
    end
  end

  task automatic check_quiet(input string tag);
    check({tag, "_rvalid"},   {63'd0, data_rvalid}, 64'd0);
    check({tag, "_rdata"},    {32'd0, data_rdata}, 64'd0);
    check({tag, "_slv_req"},  {60'd0, slv_req}, 64'd0);
    check({tag, "_err_o"},    {63'd0, err}, 64'd0);
    check({tag, "_err_code"}, {62'd0, err_code}, 64'd0);
    check({tag, "_err_addr"}, {32'd0, err_addr}, 64'd0);
  endtask

  // One master transaction. lat: cycle (after req) the target slave answers;
  // proto_c: cycle of an illegal extra request (0 = none); rst_c: cycle reset is asserted.
  task automatic txn(input logic [31:0] a, input int lat, input int proto_c, input int rst_c);
    bit          hit;
    int          sel;
    int          span;
    int          req_c;
    logic [31:0] d;
    logic [NS-1:0] sel_bit;
    exp_t        e;
    model_decode(a, hit, sel);
    d = $urandom;
    sel_bit = hit ? (NS'(1) << sel) : '0;

    @(posedge clk); #1;
    data_req   = 1'b1;
    data_addr  = a;
    data_we    = 1'($urandom);
    data_be    = 4'($urandom);
    data_wdata = $urandom;
    slv_rvalid = NS'($urandom) & ~sel_bit;
    exp_proto  = 1'b0;
    req_c      = cyc;
    e.addr = a;
    if (!hit) begin
      e.rdata = ERRD; e.is_err = 1'b1; e.code = 2'b01; e.at = req_c + 1;
    end else if (lat <= TMO) begin
      e.rdata = d;    e.is_err = 1'b0; e.code = 2'b00; e.at = req_c + lat;
    end else begin
      e.rdata = ERRD; e.is_err = 1'b1; e.code = 2'b10; e.at = req_c + TMO;
    end
    exp_q.push_back(e);

    @(negedge clk);
    check("req_onehot", {60'd0, slv_req}, {60'd0, sel_bit});
    if (hit) check("req_offset", {32'd0, slv_addr}, {32'd0, a & ~m_mask[sel]});
    check("pass_we_be_wdata", {27'd0, slv_we, slv_be, slv_wdata},
          {27'd0, data_we, data_be, data_wdata});

    span = hit ? (((lat > TMO) ? lat : TMO) + 1) : 2;
    for (int c = 1; c <= span; c++) begin
      @(posedge clk); #1;
      if (rst_c != 0 && c == rst_c + 1) begin
        arstn      = 1'b1;
        slv_rvalid = '0;
        @(negedge clk);
        check_quiet("after_reset");
        break;
      end
      exp_proto = (c == proto_c);
      data_req  = (c == proto_c);
      if (c == proto_c) begin
        data_addr = $urandom;
        last_code = 2'b11;
        last_addr = data_addr;
      end
      slv_rvalid = NS'($urandom) & ~sel_bit;
      for (int i = 0; i < NS; i++) slv_rdata[i] = $urandom;
      if (hit && c == lat) begin
        slv_rvalid[sel] = 1'b1;
        slv_rdata[sel]  = d;
      end
      if (rst_c != 0 && c == rst_c) begin
        arstn     = 1'b0;
        data_req  = 1'b0;
        exp_proto = 1'b0;
        void'(exp_q.pop_back());
        last_code = 2'b00;
        last_addr = '0;
      end
      if (c == proto_c) begin
        @(negedge clk);
        check("proto_no_slv_req", {60'd0, slv_req}, 64'd0);
      end
    end
    @(posedge clk); #1;
    data_req   = 1'b0;
    exp_proto  = 1'b0;
    slv_rvalid = '0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 arstn = 1'b1;
    @(negedge clk);
    check_quiet("reset_state");
    started = 1'b1;

    txn(32'h1000_0040, 3, 0, 0);   // slave 1, response 3 cycles later
    txn(32'h7000_0000, 1, 0, 0);   // unmapped
    txn(32'h1000_0004, 9, 0, 0);   // silent slave: timeout, late rvalid dropped
    txn(32'h2000_0100, 8, 0, 0);   // response exactly on the timeout cycle wins
    txn(32'h1000_0080, 5, 2, 0);   // illegal second request while waiting
    txn(32'h0000_0010, 2, 0, 0);   // overlapping slaves 0 and 2 -> slave 0
    txn(32'h1000_0080, 6, 0, 2);   // reset mid-wait abandons the transaction
    txn(32'h0000_0020, 1, 0, 0);   // serviced normally after reset

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int lat;
      int pc;
      int first;
      bit hit;
      int sel;
      a = $urandom;
      case ($urandom_range(0, 3))
        0: a[31:28] = 4'h0;
        1: a[31:28] = 4'h1;
        2: a[31:28] = 4'h2;
        default: ;
      endcase
      lat = $urandom_range(1, TMO + 2);
      model_decode(a, hit, sel);
      first = (lat < TMO) ? lat : TMO;
      pc = (hit && first > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, first - 1) : 0;
      txn(a, lat, pc, 0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
